vga_console_ctl: RTL and testbench
==================================

# vga_console_ctl

Text-console controller that sequences the text VGA adapter's dual-port video RAM as a Wishbone master. Accepts a byte stream (printable characters plus a small control-code set) and owns the 80×25 screen model:
- cursor position, wrap-around and scroll of rows 1–24;
- clear screen;
- the `cursor`, `cursor_on`, `cursor_type` and `flash` control inputs of the adapter.

Row 0 (service line) is never written by this block.

## Interface
Parameters:
- `VRAM_BASE`, default 16'h0000: byte base address of video RAM on the master bus.
- `FLASH_DIV`, default 25'd12_500_000: `wb_clk_i` cycles per `flash` half-period.

Ports:
- `wb_clk_i`, in, 1: single clock.
- `wb_rst_i`, in, 1: reset, synchronous, active-high.
- `ch_valid`, in, 1: input byte valid.
- `ch_data`, in, 8: input byte.
- `ch_ready`, out, 1: byte accepted on cycles where `ch_valid & ch_ready`.
- `wbm_adr_o`, out, 16: byte address; `VRAM_BASE + 2*word`.
- `wbm_dat_o`, out, 16: write data.
- `wbm_dat_i`, in, 16: read data.
- `wbm_cyc_o`, out, 1: bus cycle; equals `wbm_stb_o`.
- `wbm_stb_o`, out, 1: bus strobe.
- `wbm_we_o`, out, 1: write enable.
- `wbm_sel_o`, out, 2: byte select.
- `wbm_ack_i`, in, 1: slave acknowledge.
- `cursor`, out, 13: cursor byte address, `row*80 + col`.
- `cursor_on`, out, 1: cursor visible.
- `cursor_type`, out, 1: 0 = underline, 1 = block.
- `flash`, out, 1: blink square wave.

## Operation
- Screen: 80 columns × 25 rows, bytes 0..1999; console region is rows 1..24 (bytes 80..1999).
- Word `w` holds byte `2w` in [7:0] and byte `2w+1` in [15:8].
- Position state: `crow` (5 bit, 1..24) and `ccol` (7 bit, 0..79). `cursor` is registered; `row*80` is computed as `(row<<6)+(row<<4)`, 13-bit result.
- Byte decode in IDLE:
  - 0x08 BS: `ccol` decrements if >0, otherwise no change. No bus access.
  - 0x0D CR: `ccol` ← 0. No bus access.
  - 0x0A LF: if `crow` < 24, `crow` increments; otherwise SCROLL. `ccol` unchanged.
  - 0x0C FF: CLEAR, then `crow` ← 1, `ccol` ← 0.
  - 0x0E: `cursor_type` ← 1. 0x0F: `cursor_type` ← 0. No bus access.
  - Any other byte (including other codes 00–1F, which the adapter displays as blinking): WRCHR.
- WRCHR:
  - Write at byte address `cursor`: `wbm_sel_o` = 2'b01 for even, 2'b10 for odd; `wbm_dat_o` = `{ch,ch}`.
  - Then `ccol` increments. At 80, `ccol` ← 0 and an implicit LF is applied (SCROLL if `crow` = 24).
- SCROLL: for w = 40..959, read word w+40, then write it to word w (sel 2'b11). Then FILL words 960..999.
- CLEAR: FILL words 40..999.
- FILL: writes 16'h2020, sel 2'b11.
- States: IDLE, WRCHR, SCR_RD, SCR_WR, FILL, GAP.
  - GAP is the single idle bus cycle between accesses.
  - SCR_RD → GAP → SCR_WR → GAP → SCR_RD until w = 959, then FILL.
  - The last FILL access → IDLE.
- `ch_ready` = 1 only in IDLE. `cursor_on` = 0 whenever the state is not IDLE.
- `flash`: free-running counter. Toggles when the count reaches `FLASH_DIV-1`, then the count returns to 0. Independent of the console FSM.
- Reset: FSM → IDLE.
  - `crow` = 1, `ccol` = 0, `cursor` = 80.
  - `cursor_on` = 1, `cursor_type` = 0, `flash` = 1, flash counter = 0.
  - `ch_ready` = 1; `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o` = 0; `wbm_sel_o` = 0; `wbm_adr_o` and `wbm_dat_o` = 0.

## Timing
- All outputs are registered.
- Bus access:
  - `stb`/`cyc` rise on edge E0 with address, data and `we` stable.
  - They are held until `wbm_ack_i` is sampled high, then dropped on that same edge.
  - One GAP cycle follows before the next `stb`.
  - Read data is captured on the edge where ack is sampled.
  - With the adapter's 1-cycle registered ack, each access takes 3 cycles.
- Byte accepted at edge T:
  - No-bus code: `cursor` is updated at T+1 and `ch_ready` stays high.
  - WRCHR: `stb` at T+1, ack sampled at T+3, `cursor` updated at T+3, `ch_ready` high from T+4.
- SCROLL: 920×2×3 + 40×3 = 5640 cycles busy. CLEAR: 2880 cycles.
- A byte presented while busy is held by the source (`ch_ready` = 0) and is not lost.
- Reset mid-access: `stb`/`cyc` drop on the reset edge, and a late ack is ignored.

## Structure
- Package `vga_console_pkg`:
  - constants `COLS=80`, `FIRST_ROW=1`, `LAST_ROW=24`, `BLANK=8'h20`;
  - codes `BS`, `LF`, `CR`, `FF`, `SO`, `SI`;
  - state enum.
- Sub-module `vga_flash_gen` holds the parameterised flash divider.

## Test plan
- Reset, then send `'A'` (0x41): one write to byte addr 80, sel 2'b01, data 16'h4141. `cursor` = 81 at ack+0. `ch_ready` is low for exactly 3 cycles.
- Send 79 × `'x'` then `'y'` from col 0, row 1: `'y'` is written at byte 159. `cursor` = 160 (row 2, col 0).
- Position at row 24, send LF with word 40+40·k preloaded with k:
  - word 40 reads back 1 and word 959 reads back the old word 999;
  - words 960..999 read 16'h2020;
  - busy for 5640 cycles; `cursor` unchanged;
  - `cursor_on` low throughout.
- Send FF: 960 writes of 16'h2020 to words 40..999, with words 0..39 untouched. Afterwards `cursor` = 80.
- Bytes 0x0E, then 0x08 at col 0, then 0x0D: `cursor_type` = 1, `cursor` unchanged, and no bus activity.
- Assert `wb_rst_i` mid-SCROLL with ack delayed: `stb` is 0 on the next edge, all outputs take their reset values, and a subsequent `'A'` is written at addr 80.

Source files
------------

// File: rtl/vga_console_pkg.sv
// Shared constants, control codes and FSM encoding
// for the text console controller.
package vga_console_pkg;

  localparam int unsigned COLS = 80;
  localparam logic [4:0] FIRST_ROW = 5'd1;
  localparam logic [4:0] LAST_ROW = 5'd24;
  localparam logic [6:0] LAST_COL = 7'd79;
  localparam logic [7:0] BLANK = 8'h20;

  localparam logic [7:0] BS = 8'h08;
  localparam logic [7:0] LF = 8'h0A;
  localparam logic [7:0] FF = 8'h0C;
  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] SO = 8'h0E;
  localparam logic [7:0] SI = 8'h0F;

  localparam logic [9:0] ROW_WORDS = 10'd40;
  localparam logic [9:0] SCR_FIRST = 10'd40;
  localparam logic [9:0] SCR_LAST = 10'd959;
  localparam logic [9:0] WORD_LAST = 10'd999;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRCHR,
    ST_SCR_RD,
    ST_SCR_WR,
    ST_FILL,
    ST_GAP
  } state_t;

  function automatic logic [12:0] row_base(
    input logic [4:0] row
  );
    logic [12:0] r;
    r = {8'd0, row};
    return (r << 6) + (r << 4);
  endfunction

endpackage

// File: rtl/vga_console_ctl_if.sv
// Wishbone master bus between the console controller
// and the video RAM port.
interface vga_console_ctl_if;
  logic [15:0] wbm_adr_o;
  logic [15:0] wbm_dat_o;
  logic [15:0] wbm_dat_i;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [1:0]  wbm_sel_o;
  logic        wbm_ack_i;

  modport master (
    output wbm_adr_o, wbm_dat_o, wbm_cyc_o,
    output wbm_stb_o, wbm_we_o, wbm_sel_o,
    input  wbm_dat_i, wbm_ack_i
  );

  modport slave (
    input  wbm_adr_o, wbm_dat_o, wbm_cyc_o,
    input  wbm_stb_o, wbm_we_o, wbm_sel_o,
    output wbm_dat_i, wbm_ack_i
  );
endinterface

// File: rtl/vga_console_ctl_flash.sv
// Free-running blink generator: flash toggles
// every FLASH_DIV clock cycles.
module vga_flash_gen #(
  parameter logic [24:0] FLASH_DIV = 25'd12_500_000
) (
  input  logic clk,
  input  logic rst,
  output logic flash
);

  logic [24:0] cnt;

  // half-period counter and square-wave output
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      flash <= 1'b1;
    end else if (cnt == FLASH_DIV - 25'd1) begin
      cnt   <= '0;
      flash <= ~flash;
    end else begin
      cnt <= cnt + 25'd1;
    end
  end

endmodule

// File: rtl/vga_console_ctl.sv
// Text console controller: decodes a byte stream and
// drives video RAM writes, scroll and clear over Wishbone.
module vga_console_ctl
  import vga_console_pkg::*;
#(
  parameter logic [15:0] VRAM_BASE = 16'h0000,
  parameter logic [24:0] FLASH_DIV = 25'd12_500_000
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              ch_valid,
  input  logic [7:0]        ch_data,
  output logic              ch_ready,
  vga_console_ctl_if.master wbm,
  output logic [12:0]       cursor,
  output logic              cursor_on,
  output logic              cursor_type,
  output logic              flash
);

  state_t      state, state_n;
  state_t      after, after_n;
  logic [9:0]  word, word_n;
  logic [15:0] rdata, rdata_n;
  logic [4:0]  crow, crow_n;
  logic [6:0]  ccol, ccol_n;
  logic        ctype_n;
  logic        stb_n, we_n;
  logic [1:0]  sel_n;
  logic [15:0] adr_n, dat_n;

  function automatic logic [15:0] word_adr(
    input logic [9:0] w
  );
    return VRAM_BASE + {5'd0, w, 1'b0};
  endfunction

  // next state, bus access setup and cursor movement
  always_comb begin
    state_n = state;
    after_n = after;
    word_n  = word;
    rdata_n = rdata;
    crow_n  = crow;
    ccol_n  = ccol;
    ctype_n = cursor_type;
    stb_n   = wbm.wbm_stb_o;
    we_n    = wbm.wbm_we_o;
    sel_n   = wbm.wbm_sel_o;
    adr_n   = wbm.wbm_adr_o;
    dat_n   = wbm.wbm_dat_o;
    unique case (state)
      ST_IDLE: begin
        if (ch_valid && ch_ready) begin
          unique case (1'b1)
            (ch_data == BS): begin
              if (ccol != '0) ccol_n = ccol - 7'd1;
            end
            (ch_data == CR): ccol_n = '0;
            (ch_data == LF): begin
              if (crow < LAST_ROW) begin
                crow_n = crow + 5'd1;
              end else begin
                state_n = ST_SCR_RD;
                word_n  = SCR_FIRST;
                stb_n   = 1'b1;
                we_n    = 1'b0;
                sel_n   = 2'b11;
                adr_n   = word_adr(SCR_FIRST + ROW_WORDS);
              end
            end
            (ch_data == FF): begin
              crow_n  = FIRST_ROW;
              ccol_n  = '0;
              state_n = ST_FILL;
              word_n  = SCR_FIRST;
              stb_n   = 1'b1;
              we_n    = 1'b1;
              sel_n   = 2'b11;
              adr_n   = word_adr(SCR_FIRST);
              dat_n   = {BLANK, BLANK};
            end
            (ch_data == SO): ctype_n = 1'b1;
            (ch_data == SI): ctype_n = 1'b0;
            default: begin
              state_n = ST_WRCHR;
              stb_n   = 1'b1;
              we_n    = 1'b1;
              sel_n   = cursor[0] ? 2'b10 : 2'b01;
              adr_n   = VRAM_BASE
                      + {3'd0, cursor[12:1], 1'b0};
              dat_n   = {ch_data, ch_data};
            end
          endcase
        end
      end
      ST_WRCHR: begin
        if (wbm.wbm_ack_i) begin
          stb_n   = 1'b0;
          state_n = ST_GAP;
          after_n = ST_IDLE;
          if (ccol == LAST_COL) begin
            ccol_n = '0;
            if (crow < LAST_ROW) begin
              crow_n = crow + 5'd1;
            end else begin
              after_n = ST_SCR_RD;
              word_n  = SCR_FIRST;
            end
          end else begin
            ccol_n = ccol + 7'd1;
          end
        end
      end
      ST_SCR_RD: begin
        if (wbm.wbm_ack_i) begin
          stb_n   = 1'b0;
          rdata_n = wbm.wbm_dat_i;
          state_n = ST_GAP;
          after_n = ST_SCR_WR;
        end
      end
      ST_SCR_WR: begin
        if (wbm.wbm_ack_i) begin
          stb_n   = 1'b0;
          state_n = ST_GAP;
          word_n  = word + 10'd1;
          after_n = (word == SCR_LAST) ? ST_FILL
                                       : ST_SCR_RD;
        end
      end
      ST_FILL: begin
        if (wbm.wbm_ack_i) begin
          stb_n   = 1'b0;
          state_n = ST_GAP;
          if (word == WORD_LAST) begin
            after_n = ST_IDLE;
          end else begin
            word_n  = word + 10'd1;
            after_n = ST_FILL;
          end
        end
      end
      ST_GAP: begin
        state_n = after;
        unique case (after)
          ST_SCR_RD: begin
            stb_n = 1'b1;
            we_n  = 1'b0;
            sel_n = 2'b11;
            adr_n = word_adr(word + ROW_WORDS);
          end
          ST_SCR_WR: begin
            stb_n = 1'b1;
            we_n  = 1'b1;
            sel_n = 2'b11;
            adr_n = word_adr(word);
            dat_n = rdata;
          end
          ST_FILL: begin
            stb_n = 1'b1;
            we_n  = 1'b1;
            sel_n = 2'b11;
            adr_n = word_adr(word);
            dat_n = {BLANK, BLANK};
          end
          default: state_n = ST_IDLE;
        endcase
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // state, position and all registered outputs
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state         <= ST_IDLE;
      after         <= ST_IDLE;
      word          <= '0;
      rdata         <= '0;
      crow          <= FIRST_ROW;
      ccol          <= '0;
      cursor        <= row_base(FIRST_ROW);
      cursor_type   <= 1'b0;
      cursor_on     <= 1'b1;
      ch_ready      <= 1'b1;
      wbm.wbm_stb_o <= 1'b0;
      wbm.wbm_cyc_o <= 1'b0;
      wbm.wbm_we_o  <= 1'b0;
      wbm.wbm_sel_o <= '0;
      wbm.wbm_adr_o <= '0;
      wbm.wbm_dat_o <= '0;
    end else begin
      state         <= state_n;
      after         <= after_n;
      word          <= word_n;
      rdata         <= rdata_n;
      crow          <= crow_n;
      ccol          <= ccol_n;
      cursor        <= row_base(crow_n) + {6'd0, ccol_n};
      cursor_type   <= ctype_n;
      cursor_on     <= (state_n == ST_IDLE);
      ch_ready      <= (state_n == ST_IDLE);
      wbm.wbm_stb_o <= stb_n;
      wbm.wbm_cyc_o <= stb_n;
      wbm.wbm_we_o  <= we_n;
      wbm.wbm_sel_o <= sel_n;
      wbm.wbm_adr_o <= adr_n;
      wbm.wbm_dat_o <= dat_n;
    end
  end

  vga_flash_gen #(
    .FLASH_DIV(FLASH_DIV)
  ) u_flash (
    .clk  (wb_clk_i),
    .rst  (wb_rst_i),
    .flash(flash)
  );

endmodule

// File: tb/tb_vga_console_ctl.sv
// Randomized bench for vga_console_ctl against a
// byte-level screen model and a video RAM slave.
module tb_vga_console_ctl;
  import vga_console_pkg::*;

  localparam logic [15:0] BASE = 16'h0400;
  localparam logic [24:0] FDIV = 25'd7;
  localparam int FDIV_I = 7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ch_valid = 1'b0;
  logic [7:0]  ch_data = 8'h00;
  logic        ch_ready;
  logic [12:0] cursor;
  logic        cursor_on;
  logic        cursor_type;
  logic        flash;

  vga_console_ctl_if bus ();

  vga_console_ctl #(
    .VRAM_BASE(BASE),
    .FLASH_DIV(FDIV)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .ch_valid   (ch_valid),
    .ch_data    (ch_data),
    .ch_ready   (ch_ready),
    .wbm        (bus),
    .cursor     (cursor),
    .cursor_on  (cursor_on),
    .cursor_type(cursor_type),
    .flash      (flash)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // video RAM slave with registered ack
  logic [15:0] vram [0:1023];
  logic [15:0] pre [0:999];
  logic        pre_go = 1'b0;
  int          ack_delay = 0;
  int          wait_cnt = 0;
  int          n_acc = 0;
  int          n_bad = 0;
  int          n_cyc_err = 0;
  int          fk = 0;
  logic [15:0] last_adr = '0;
  logic [15:0] last_dat = '0;
  logic [1:0]  last_sel = '0;
  logic [15:0] off;
  logic [9:0]  wi;

  assign off = bus.wbm_adr_o - BASE;
  assign wi  = 10'(off >> 1);

  always @(posedge clk) begin
    if (rst) fk <= 0;
    else fk <= fk + 1;
  end

  always @(posedge clk) begin
    if (pre_go)
      for (int i = 0; i < 1000; i++) vram[i] <= pre[i];
    if (bus.wbm_cyc_o !== bus.wbm_stb_o)
      n_cyc_err <= n_cyc_err + 1;
    if (bus.wbm_stb_o && bus.wbm_ack_i) begin
      n_acc <= n_acc + 1;
      if (bus.wbm_we_o) begin
        last_adr <= bus.wbm_adr_o;
        last_dat <= bus.wbm_dat_o;
        last_sel <= bus.wbm_sel_o;
      end
    end
    if (bus.wbm_stb_o && !bus.wbm_ack_i) begin
      if (wait_cnt < ack_delay) begin
        wait_cnt <= wait_cnt + 1;
      end else begin
        wait_cnt <= 0;
        bus.wbm_ack_i <= 1'b1;
        if (off >= 16'd2000) begin
          n_bad <= n_bad + 1;
        end else if (bus.wbm_we_o) begin
          if (bus.wbm_sel_o[0])
            vram[wi][7:0] <= bus.wbm_dat_o[7:0];
          if (bus.wbm_sel_o[1])
            vram[wi][15:8] <= bus.wbm_dat_o[15:8];
        end else begin
          bus.wbm_dat_i <= vram[wi];
        end
      end
    end else begin
      bus.wbm_ack_i <= 1'b0;
      wait_cnt <= 0;
    end
  end

  // screen model: plain byte array plus cursor
  logic [7:0] scr [0:1999];
  int mrow = 1;
  int mcol = 0;
  int mtype = 0;

  task automatic m_lf(inout int acc);
    if (mrow < 24) begin
      mrow++;
    end else begin
      for (int i = 80; i < 1920; i++) scr[i] = scr[i + 80];
      for (int i = 1920; i < 2000; i++) scr[i] = 8'h20;
      acc += 1880;
    end
  endtask

  task automatic m_byte(input logic [7:0] b,
                        output int acc);
    acc = 0;
    case (b)
      8'h08: if (mcol > 0) mcol--;
      8'h0D: mcol = 0;
      8'h0A: m_lf(acc);
      8'h0C: begin
        for (int i = 80; i < 2000; i++) scr[i] = 8'h20;
        mrow = 1;
        mcol = 0;
        acc = 960;
      end
      8'h0E: mtype = 1;
      8'h0F: mtype = 0;
      default: begin
        scr[mrow * 80 + mcol] = b;
        acc = 1;
        mcol++;
        if (mcol == 80) begin
          mcol = 0;
          m_lf(acc);
        end
      end
    endcase
  endtask

  task automatic cmp_screen(input string tag);
    int bad;
    logic [15:0] w;
    logic [7:0] g;
    bad = 0;
    for (int i = 0; i < 2000; i++) begin
      w = vram[i / 2];
      g = (i % 2 == 1) ? w[15:8] : w[7:0];
      if (g !== scr[i]) bad++;
    end
    chk(tag, bad, 0);
  endtask

  task automatic send(input logic [7:0] b,
                      output int busy);
    int ea, a0, lowon, k;
    m_byte(b, ea);
    k = 0;
    while (ch_ready !== 1'b1 && k < 20000) begin
      @(negedge clk);
      k++;
    end
    chk("ready_wait", ch_ready, 1);
    a0 = n_acc;
    ch_valid = 1'b1;
    ch_data = b;
    @(posedge clk);
    @(negedge clk);
    ch_valid = 1'b0;
    busy = 0;
    lowon = 0;
    while (ch_ready === 1'b0 && busy < 20000) begin
      busy++;
      if (cursor_on !== 1'b0) lowon++;
      @(negedge clk);
    end
    chk("busy", busy, 3 * ea);
    chk("accesses", n_acc - a0, ea);
    chk("cursor_on_busy", lowon, 0);
    chk("cursor", cursor, mrow * 80 + mcol);
    chk("cursor_type", cursor_type, mtype);
    chk("cursor_on", cursor_on, 1);
    chk("flash", flash, 1 ^ ((fk / FDIV_I) % 2));
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_stb"}, bus.wbm_stb_o, 0);
    chk({tag, "_cyc"}, bus.wbm_cyc_o, 0);
    chk({tag, "_we"}, bus.wbm_we_o, 0);
    chk({tag, "_sel"}, bus.wbm_sel_o, 0);
    chk({tag, "_adr"}, bus.wbm_adr_o, 0);
    chk({tag, "_dat"}, bus.wbm_dat_o, 0);
    chk({tag, "_ready"}, ch_ready, 1);
    chk({tag, "_cursor"}, cursor, 80);
    chk({tag, "_cur_on"}, cursor_on, 1);
    chk({tag, "_ctype"}, cursor_type, 0);
    chk({tag, "_flash"}, flash, 1);
  endtask

  initial begin
    int busy, bad, k, r;
    logic [15:0] old999;
    logic [7:0] b;

    for (int w = 0; w < 1000; w++) pre[w] = 16'($urandom);
    for (int j = 0; j < 24; j++) pre[40 + 40 * j] = 16'(j);
    for (int w = 0; w < 1000; w++) begin
      scr[2 * w]     = pre[w][7:0];
      scr[2 * w + 1] = pre[w][15:8];
    end
    old999 = pre[999];
    pre_go = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    pre_go = 1'b0;
    chk_reset_outs("rst");
    rst = 1'b0;
    @(negedge clk);

    send(8'h41, busy);
    chk("A_busy", busy, 3);
    chk("A_adr", last_adr, BASE + 16'd80);
    chk("A_sel", last_sel, 2'b01);
    chk("A_dat", last_dat, 16'h4141);

    send(CR, busy);
    for (int i = 0; i < 79; i++) send(8'h78, busy);
    send(8'h79, busy);
    chk("y_adr", last_adr, BASE + 16'd158);
    chk("y_sel", last_sel, 2'b10);
    chk("y_dat", last_dat, 16'h7979);
    chk("y_cursor", cursor, 160);

    while (mrow < 24) send(LF, busy);
    send(LF, busy);
    chk("scroll_busy", busy, 5640);
    chk("scroll_cursor", cursor, 1920);
    chk("scroll_w40", vram[40], 16'd1);
    chk("scroll_w959", vram[959], old999);
    bad = 0;
    for (int w = 960; w < 1000; w++)
      if (vram[w] !== 16'h2020) bad++;
    chk("scroll_fill", bad, 0);
    cmp_screen("scroll_screen");

    send(FF, busy);
    chk("clear_busy", busy, 2880);
    chk("clear_cursor", cursor, 80);
    bad = 0;
    for (int w = 0; w < 40; w++)
      if (vram[w] !== pre[w]) bad++;
    chk("row0_kept", bad, 0);
    cmp_screen("clear_screen");

    k = n_acc;
    send(SO, busy);
    send(BS, busy);
    send(CR, busy);
    chk("ctl_ctype", cursor_type, 1);
    chk("ctl_cursor", cursor, 80);
    chk("ctl_nobus", n_acc - k, 0);

    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 99);
      if (r < 70) b = 8'($urandom_range(32, 126));
      else if (r < 80) begin
        case ($urandom_range(0, 3))
          0: b = BS;
          1: b = CR;
          2: b = SO;
          default: b = SI;
        endcase
      end
      else if (r < 85) b = 8'($urandom_range(0, 31));
      else if (r < 95) b = LF;
      else if (r < 96) b = FF;
      else b = 8'($urandom_range(128, 255));
      send(b, busy);
    end
    cmp_screen("rand_screen");

    while (mrow < 24) send(LF, busy);
    ack_delay = 2;
    k = 0;
    while (ch_ready !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    ch_valid = 1'b1;
    ch_data = LF;
    @(posedge clk);
    @(negedge clk);
    ch_valid = 1'b0;
    repeat (200) @(negedge clk);
    k = 0;
    while (bus.wbm_stb_o !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("mid_stb", bus.wbm_stb_o, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_outs("midrst");
    @(negedge clk);
    rst = 1'b0;
    ack_delay = 0;
    mrow = 1;
    mcol = 0;
    mtype = 0;
    send(8'h41, busy);
    chk("rA_adr", last_adr, BASE + 16'd80);
    chk("rA_sel", last_sel, 2'b01);
    chk("rA_dat", last_dat, 16'h4141);

    chk("cyc_eq_stb", n_cyc_err, 0);
    chk("adr_range", n_bad, 0);
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
